// File: rtl/alarm_led_driver_pkg.sv
// alarm_led_driver_pkg: shared state encoding and default timing parameters
package alarm_led_driver_pkg;
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_QUAL  = 2'd1,
        S_ALARM = 2'd2,
        S_HOLD  = 2'd3
    } state_t;
    localparam int DEF_QUAL_CYCLES = 4;
    localparam int DEF_BLINK_HALF  = 8;
    localparam int DEF_CNT_W       = 8;
endpackage

// File: rtl/alarm_led_driver_if.sv
// alarm_led_driver_if: request/acknowledge inputs and LED/alarm outputs of the driver
interface alarm_led_driver_if
    import alarm_led_driver_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
);
    logic             led_req;
    logic             ack;
    logic             count_clr;
    logic             led_out;
    logic             alarm_active;
    logic [CNT_W-1:0] alarm_count;
    modport master (output led_req, ack, count_clr, input led_out, alarm_active, alarm_count);
    modport slave  (input led_req, ack, count_clr, output led_out, alarm_active, alarm_count);
endinterface

// File: rtl/alarm_led_driver_blink_timer.sv
// alarm_led_driver_blink_timer: half-period counter whose registered blink output drives the LED
module alarm_led_driver_blink_timer
    import alarm_led_driver_pkg::*;
#(
    parameter int BLINK_HALF = DEF_BLINK_HALF
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic en,
    output logic blink
);
    localparam int CW = $clog2(BLINK_HALF + 1);
    logic [CW-1:0] cnt;
    logic          wrap;
    assign wrap = cnt == CW'(BLINK_HALF - 1);
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            blink <= 1'b0;
        end else if (start) begin
            cnt   <= '0;
            blink <= 1'b1;
        end else if (en) begin
            cnt   <= wrap ? '0 : cnt + 1'b1;
            blink <= blink ^ wrap;
        end
    end
endmodule

// File: rtl/alarm_led_driver.sv
// alarm_led_driver: qualifies led_req, latches and blinks an alarm until ack, counts alarms
module alarm_led_driver
    import alarm_led_driver_pkg::*;
#(
    parameter int QUAL_CYCLES = DEF_QUAL_CYCLES,
    parameter int BLINK_HALF  = DEF_BLINK_HALF,
    parameter int CNT_W       = DEF_CNT_W
) (
    input logic               clk,
    input logic               rst,
    alarm_led_driver_if.slave bus
);
    localparam int QW = $clog2(QUAL_CYCLES + 1);
    state_t           state, nxt;
    logic [QW-1:0]    qual_cnt, qual_nxt;
    logic             alarm_active;
    logic [CNT_W-1:0] alarm_count;
    logic             entry, hold_entry, blink;
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:  nxt = bus.led_req ? (QUAL_CYCLES == 1 ? S_ALARM : S_QUAL) : S_IDLE;
            S_QUAL:  nxt = !bus.led_req ? S_IDLE : qual_cnt == QW'(QUAL_CYCLES - 1) ? S_ALARM : S_QUAL;
            S_ALARM: nxt = bus.ack ? (bus.led_req ? S_HOLD : S_IDLE) : S_ALARM;
            default: nxt = bus.led_req ? S_HOLD : S_IDLE;
        endcase
        qual_nxt = nxt != S_QUAL ? '0 : state == S_QUAL ? qual_cnt + 1'b1 : QW'(1);
    end
    assign entry      = nxt == S_ALARM && state != S_ALARM;
    assign hold_entry = nxt == S_HOLD && state != S_HOLD;
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            qual_cnt     <= '0;
            alarm_active <= 1'b0;
            alarm_count  <= '0;
        end else begin
            state        <= nxt;
            qual_cnt     <= qual_nxt;
            alarm_active <= nxt == S_ALARM;
            alarm_count  <= bus.count_clr ? CNT_W'(entry) : alarm_count + CNT_W'(entry && !(&alarm_count));
        end
    end
    // Timer is held in reset outside ALARM/HOLD; start also latches the steady-on level for HOLD
    alarm_led_driver_blink_timer #(.BLINK_HALF(BLINK_HALF)) u_blink (
        .clk   (clk),
        .rst   (rst || nxt == S_IDLE || nxt == S_QUAL),
        .start (entry || hold_entry),
        .en    (state == S_ALARM && nxt == S_ALARM),
        .blink (blink)
    );
    assign bus.led_out      = blink;
    assign bus.alarm_active = alarm_active;
    assign bus.alarm_count  = alarm_count;
endmodule

// File: tb/tb_alarm_led_driver.sv
// tb_alarm_led_driver: directed checks of qualification, blinking, ack/hold, counting and reset
module tb_alarm_led_driver;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    always #5 clk = ~clk;
    alarm_led_driver_if #(.CNT_W(8)) ifa ();
    alarm_led_driver_if #(.CNT_W(2)) ifb ();
    alarm_led_driver #(.QUAL_CYCLES(4), .BLINK_HALF(8), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );
    alarm_led_driver #(.QUAL_CYCLES(4), .BLINK_HALF(8), .CNT_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask
    task automatic set_in(input logic req, input logic a, input logic clr);
        ifa.led_req = req;
        ifa.ack = a;
        ifa.count_clr = clr;
        ifb.led_req = req;
        ifb.ack = a;
        ifb.count_clr = clr;
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic run_alarm(input logic clr, input logic [31:0] exp8, input logic [31:0] exp2);
        set_in(1'b1, 1'b0, 1'b0);
        repeat (3) step();
        set_in(1'b1, 1'b0, clr);
        step();
        chk("entry_active", 32'(ifa.alarm_active), 1);
        chk("entry_count", 32'(ifa.alarm_count), exp8);
        chk("entry_count_sat", 32'(ifb.alarm_count), exp2);
        set_in(1'b0, 1'b1, 1'b0);
        step();
        chk("ack_idle_active", 32'(ifa.alarm_active), 0);
        set_in(1'b0, 1'b0, 1'b0);
    endtask
    initial begin
        set_in(1'b0, 1'b0, 1'b0);
        step();
        step();
        chk("rst_led", 32'(ifa.led_out), 0);
        chk("rst_active", 32'(ifa.alarm_active), 0);
        chk("rst_count", 32'(ifa.alarm_count), 0);
        chk("rst_count_sat", 32'(ifb.alarm_count), 0);
        rst = 1'b0;
        set_in(1'b1, 1'b0, 1'b0);
        repeat (3) step();
        chk("short_req_active", 32'(ifa.alarm_active), 0);
        set_in(1'b0, 1'b0, 1'b0);
        step();
        chk("short_req_active_after", 32'(ifa.alarm_active), 0);
        chk("short_req_count", 32'(ifa.alarm_count), 0);
        set_in(1'b1, 1'b0, 1'b0);
        repeat (3) step();
        chk("qual_k2_active", 32'(ifa.alarm_active), 0);
        chk("qual_k2_led", 32'(ifa.led_out), 0);
        step();
        chk("qual_k3_active", 32'(ifa.alarm_active), 1);
        chk("qual_k3_led", 32'(ifa.led_out), 1);
        chk("qual_k3_count", 32'(ifa.alarm_count), 1);
        set_in(1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 16; i++) begin
            step();
            chk($sformatf("blink_%0d", i), 32'(ifa.led_out), (i < 8 || i == 16) ? 1 : 0);
        end
        chk("latched_active", 32'(ifa.alarm_active), 1);
        set_in(1'b0, 1'b1, 1'b0);
        step();
        chk("ack_led", 32'(ifa.led_out), 0);
        chk("ack_active", 32'(ifa.alarm_active), 0);
        set_in(1'b1, 1'b0, 1'b0);
        repeat (4) step();
        chk("alarm2_count", 32'(ifa.alarm_count), 2);
        chk("alarm2_count_sat", 32'(ifb.alarm_count), 2);
        set_in(1'b1, 1'b1, 1'b0);
        step();
        chk("hold_led", 32'(ifa.led_out), 1);
        chk("hold_active", 32'(ifa.alarm_active), 0);
        for (int i = 1; i <= 10; i++) begin
            step();
            chk($sformatf("hold_steady_%0d", i), 32'({ifa.led_out, ifa.alarm_active}), 32'b10);
        end
        set_in(1'b0, 1'b0, 1'b0);
        step();
        chk("hold_exit_led", 32'(ifa.led_out), 0);
        chk("hold_exit_active", 32'(ifa.alarm_active), 0);
        run_alarm(1'b0, 3, 3);
        run_alarm(1'b0, 4, 3);
        run_alarm(1'b0, 5, 3);
        run_alarm(1'b1, 1, 1);
        set_in(1'b0, 1'b0, 1'b1);
        step();
        chk("clr_idle_count", 32'(ifa.alarm_count), 0);
        chk("clr_idle_count_sat", 32'(ifb.alarm_count), 0);
        set_in(1'b1, 1'b0, 1'b0);
        repeat (4) step();
        chk("pre_rst_led", 32'(ifa.led_out), 1);
        repeat (2) step();
        chk("pre_rst_led2", 32'(ifa.led_out), 1);
        rst = 1'b1;
        step();
        chk("mid_rst_led", 32'(ifa.led_out), 0);
        chk("mid_rst_active", 32'(ifa.alarm_active), 0);
        chk("mid_rst_count", 32'(ifa.alarm_count), 0);
        chk("mid_rst_count_sat", 32'(ifb.alarm_count), 0);
        rst = 1'b0;
        repeat (3) step();
        chk("post_rst_requal_active", 32'(ifa.alarm_active), 0);
        step();
        chk("post_rst_alarm_active", 32'(ifa.alarm_active), 1);
        chk("post_rst_alarm_count", 32'(ifa.alarm_count), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
